gate_truth_checker: RTL and testbench

Sequential self-test block that drives the two-input stimulus into a logic-gate block and checks its seven outputs (AND, OR, NOT, NAND, NOR, XOR, XNOR). On a start pulse it sweeps all four input combinations, waits a settle time per vector, and compares the returned outputs against internally computed expected values. It then reports pass/fail, a mismatch count, the accumulated failing-output mask and the first failing vector. It sits on the test side of the gate blocks, for board bring-up and regression.

---
 rtl/gate_truth_checker_if.sv | 24 ++
 rtl/gate_truth_checker.sv | 111 +++++++++++
 tb/tb_gate_truth_checker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_checker_if.sv
// Stimulus/response and result bundle between a gate truth checker and its user.
// The checker side uses the slave modport; the controlling/gate side uses master.
interface gate_truth_checker_if;
   logic       start;
   logic       a;
   logic       b;
   logic [6:0] res_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [6:0] fail_mask;
   logic [1:0] first_fail_vec;

   modport master (
      output start, res_in,
      input  a, b, busy, done, pass, err_count, fail_mask, first_fail_vec
   );

   modport slave (
      input  start, res_in,
      output a, b, busy, done, pass, err_count, fail_mask, first_fail_vec
   );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps {a,b} through 00,01,10,11 into a two-input gate block, holds each vector
// SETTLE cycles, then compares the seven returned gate outputs against expectation.
module gate_truth_checker #(
   parameter int SETTLE       = 2,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   gate_truth_checker_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       clear, capture;

   logic [6:0] expected, mismatch;
   logic       vec_fail;
   logic [2:0] err_upd;

   logic       pass_r;
   logic [2:0] err_count_r;
   logic [6:0] fail_mask_r;
   logic [1:0] first_fail_r;

   // Bit order: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor
   function automatic logic [6:0] gate_expect(input logic va, input logic vb);
      gate_expect = {~(va ^ vb), va ^ vb, ~(va | vb), ~(va & vb), ~va, va | vb, va & vb};
   endfunction

   assign expected = gate_expect(idx[1], idx[0]);
   assign mismatch = bus.res_in ^ expected;
   assign vec_fail = |mismatch;
   assign err_upd  = err_count_r + 3'(vec_fail);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      clear     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = DRIVE;
               idx_nxt   = 2'd0;
               cnt_nxt   = 4'd0;
               clear     = 1'b1;
            end
         end
         DRIVE: begin
            if (cnt == 4'(SETTLE - 1)) state_nxt = SAMPLE;
            else                       cnt_nxt   = cnt + 4'd1;
         end
         SAMPLE: begin
            capture = 1'b1;
            if (idx == 2'd3 || (STOP_ON_FAIL && vec_fail)) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DRIVE;
               idx_nxt   = idx + 2'd1;
               cnt_nxt   = 4'd0;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= 2'd0;
         cnt          <= 4'd0;
         pass_r       <= 1'b0;
         err_count_r  <= 3'd0;
         fail_mask_r  <= 7'd0;
         first_fail_r <= 2'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         if (clear) begin
            pass_r       <= 1'b0;
            err_count_r  <= 3'd0;
            fail_mask_r  <= 7'd0;
            first_fail_r <= 2'd0;
         end else if (capture) begin
            if (vec_fail) begin
               err_count_r <= err_upd;
               fail_mask_r <= fail_mask_r | mismatch;
               if (err_count_r == 3'd0) first_fail_r <= idx;
            end
            // pass becomes visible together with the done pulse
            if (state_nxt == DONE) pass_r <= (err_upd == 3'd0);
         end
      end
   end

   assign bus.busy           = (state == DRIVE) || (state == SAMPLE);
   assign bus.a              = bus.busy ? idx[1] : 1'b0;
   assign bus.b              = bus.busy ? idx[0] : 1'b0;
   assign bus.done           = (state == DONE);
   assign bus.pass           = pass_r;
   assign bus.err_count      = err_count_r;
   assign bus.fail_mask      = fail_mask_r;
   assign bus.first_fail_vec = first_fail_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: four instances cover SETTLE/STOP_ON_FAIL
// variants, driven by fault-injected and delayed gate models.
module tb_gate_truth_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [3:0] start_r = 4'd0;
   logic [6:0] flip    = 7'd0;
   logic [6:0] force1  = 7'd0;
   logic [6:0] force0  = 7'd0;

   gate_truth_checker_if ifc0 ();
   gate_truth_checker_if ifc1 ();
   gate_truth_checker_if ifc2 ();
   gate_truth_checker_if ifc3 ();

   gate_truth_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
   gate_truth_checker #(.SETTLE(2), .STOP_ON_FAIL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
   gate_truth_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
   gate_truth_checker #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) dut3 (.clk(clk), .rst(rst), .bus(ifc3));

   function automatic logic [6:0] gate_model(input logic x, input logic y);
      logic [6:0] g;
      g[0] = x & y;
      g[1] = x | y;
      g[2] = ~x;
      g[3] = ~(x & y);
      g[4] = ~(x | y);
      g[5] = x ^ y;
      g[6] = ~(x ^ y);
      return g;
   endfunction

   // DUT0/DUT1 see the gate model with injected faults; DUT2/DUT3 see a 2-cycle-late model.
   logic [6:0] d1_2, d2_2, d1_3, d2_3;
   always @(posedge clk) begin
      d1_2 <= gate_model(ifc2.a, ifc2.b);
      d2_2 <= d1_2;
      d1_3 <= gate_model(ifc3.a, ifc3.b);
      d2_3 <= d1_3;
   end

   assign ifc0.start  = start_r[0];
   assign ifc1.start  = start_r[1];
   assign ifc2.start  = start_r[2];
   assign ifc3.start  = start_r[3];
   assign ifc0.res_in = ((gate_model(ifc0.a, ifc0.b) ^ flip) | force1) & ~force0;
   assign ifc1.res_in = ((gate_model(ifc1.a, ifc1.b) ^ flip) | force1) & ~force0;
   assign ifc2.res_in = d2_2;
   assign ifc3.res_in = d2_3;

   wire [3:0] done_w = {ifc3.done, ifc2.done, ifc1.done, ifc0.done};
   wire [3:0] pass_w = {ifc3.pass, ifc2.pass, ifc1.pass, ifc0.pass};
   logic [2:0] err_w  [4];
   logic [6:0] mask_w [4];
   logic [1:0] ffv_w  [4];
   assign err_w[0] = ifc0.err_count;       assign err_w[1] = ifc1.err_count;
   assign err_w[2] = ifc2.err_count;       assign err_w[3] = ifc3.err_count;
   assign mask_w[0] = ifc0.fail_mask;      assign mask_w[1] = ifc1.fail_mask;
   assign mask_w[2] = ifc2.fail_mask;      assign mask_w[3] = ifc3.fail_mask;
   assign ffv_w[0] = ifc0.first_fail_vec;  assign ffv_w[1] = ifc1.first_fail_vec;
   assign ffv_w[2] = ifc2.first_fail_vec;  assign ffv_w[3] = ifc3.first_fail_vec;

   typedef struct {
      int         dut;
      logic [6:0] flip;
      logic [6:0] f1;
      logic [6:0] f0;
      int         done_cyc;
      logic [2:0] err;
      logic [6:0] mask;
      logic [1:0] ffv;
      logic       pass;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Start in cycle 0, return the cycle done was seen (-1 if never), end in the cycle after done.
   task automatic run_sweep(input int d, output int dc);
      cyc = 0;
      start_r[d] = 1'b1;
      tick();
      start_r[d] = 1'b0;
      dc = -1;
      while (dc < 0 && cyc < 100) begin
         if (done_w[d]) dc = cyc;
         else tick();
      end
      tick();
   endtask

   initial begin
      int dc;
      int seen13, seen27, other;

      vecs[0]  = '{0, 7'h00, 7'h00, 7'h00,      13, 3'd0, 7'h00,       2'b00, 1'b1};
      vecs[1]  = '{0, 7'h00, 7'h00, 7'b0100000, 13, 3'd2, 7'b0100000,  2'b01, 1'b0};
      vecs[2]  = '{0, 7'h00, 7'b0000001, 7'h00, 13, 3'd3, 7'b0000001,  2'b00, 1'b0};
      vecs[3]  = '{0, 7'h00, 7'h00, 7'b0000100, 13, 3'd2, 7'b0000100,  2'b00, 1'b0};
      vecs[4]  = '{0, 7'h7F, 7'h00, 7'h00,      13, 3'd4, 7'h7F,       2'b00, 1'b0};
      vecs[5]  = '{0, 7'h00, 7'b0010000, 7'h00, 13, 3'd3, 7'b0010000,  2'b01, 1'b0};
      vecs[6]  = '{1, 7'b0001000, 7'h00, 7'h00,  4, 3'd1, 7'b0001000,  2'b00, 1'b0};
      vecs[7]  = '{1, 7'h00, 7'h00, 7'b0100000,  7, 3'd1, 7'b0100000,  2'b01, 1'b0};
      vecs[8]  = '{1, 7'h00, 7'h00, 7'b1000000,  4, 3'd1, 7'b1000000,  2'b00, 1'b0};
      vecs[9]  = '{1, 7'h00, 7'h00, 7'b0000001, 13, 3'd1, 7'b0000001,  2'b11, 1'b0};
      vecs[10] = '{1, 7'h00, 7'h00, 7'h00,      13, 3'd0, 7'h00,       2'b00, 1'b1};
      vecs[11] = '{2, 7'h00, 7'h00, 7'h00,       9, 3'd3, 7'h7F,       2'b01, 1'b0};
      vecs[12] = '{3, 7'h00, 7'h00, 7'h00,      17, 3'd0, 7'h00,       2'b00, 1'b1};

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_a",    ifc0.a, 0);
      check("rst_b",    ifc0.b, 0);
      check("rst_busy", ifc0.busy, 0);
      check("rst_done", ifc0.done, 0);
      check("rst_pass", ifc0.pass, 0);
      check("rst_err",  ifc0.err_count, 0);
      check("rst_mask", ifc0.fail_mask, 0);
      check("rst_ffv",  ifc0.first_fail_vec, 0);
      repeat (3) tick();

      // Golden sweep, cycle by cycle
      cyc = 0;
      start_r[0] = 1'b1;
      for (int c = 0; c <= 14; c++) begin
         if (c >= 1 && c <= 12) begin
            check("trace_ab",   {ifc0.a, ifc0.b}, (c - 1) / 3);
            check("trace_busy", ifc0.busy, 1);
            check("trace_done", ifc0.done, 0);
         end else if (c == 13) begin
            check("trace_done13", ifc0.done, 1);
            check("trace_busy13", ifc0.busy, 0);
            check("trace_ab13",   {ifc0.a, ifc0.b}, 0);
            check("trace_pass13", ifc0.pass, 1);
         end else if (c == 14) begin
            check("trace_done14", ifc0.done, 0);
         end
         tick();
         start_r[0] = 1'b0;
      end

      foreach (vecs[i]) begin
         flip   = vecs[i].flip;
         force1 = vecs[i].f1;
         force0 = vecs[i].f0;
         run_sweep(vecs[i].dut, dc);
         check($sformatf("v%0d_done_cyc", i), dc, vecs[i].done_cyc);
         check($sformatf("v%0d_err", i),  err_w[vecs[i].dut],  vecs[i].err);
         check($sformatf("v%0d_mask", i), mask_w[vecs[i].dut], vecs[i].mask);
         check($sformatf("v%0d_pass", i), pass_w[vecs[i].dut], vecs[i].pass);
         if (vecs[i].err != 0)
            check($sformatf("v%0d_ffv", i), ffv_w[vecs[i].dut], vecs[i].ffv);
         tick();
      end

      // start during a sweep and in the DONE cycle is ignored
      flip = 7'd0; force1 = 7'd0; force0 = 7'b0100000;
      seen13 = 0; seen27 = 0; other = 0;
      cyc = 0;
      for (int c = 0; c <= 30; c++) begin
         start_r[0] = (c == 0 || c == 5 || c == 13 || c == 14);
         if (c == 14) check("ign_err_held", ifc0.err_count, 2);
         if (c == 15) begin
            check("ign_busy15", ifc0.busy, 1);
            check("ign_err15",  ifc0.err_count, 0);
            check("ign_mask15", ifc0.fail_mask, 0);
            check("ign_pass15", ifc0.pass, 0);
         end
         if (ifc0.done) begin
            if (c == 13)      seen13++;
            else if (c == 27) seen27++;
            else              other++;
         end
         tick();
      end
      start_r[0] = 1'b0;
      check("ign_done13", seen13, 1);
      check("ign_done27", seen27, 1);
      check("ign_other",  other, 0);
      check("ign_err2",   ifc0.err_count, 2);

      // rst in cycle 6 abandons the sweep
      other = 0;
      cyc = 0;
      for (int c = 0; c <= 30; c++) begin
         start_r[0] = (c == 0);
         rst = (c == 6);
         if (c == 6) check("rst6_busy", ifc0.busy, 1);
         if (c == 7) begin
            check("rst7_busy", ifc0.busy, 0);
            check("rst7_ab",   {ifc0.a, ifc0.b}, 0);
            check("rst7_err",  ifc0.err_count, 0);
            check("rst7_pass", ifc0.pass, 0);
            check("rst7_mask", ifc0.fail_mask, 0);
         end
         if (c >= 7 && ifc0.done) other++;
         tick();
      end
      rst = 1'b0;
      check("rst_no_done", other, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
